// File: rtl/rggen_avalon_arbiter.sv
// rggen_avalon_arbiter: round-robin arbiter that lets several Avalon-MM hosts
// share a single rggen register agent. A grant is held for a whole transfer,
// and only the granted host sees the agent's waitrequest.
module rggen_avalon_arbiter #(
  parameter int HOSTS         = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
)(
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [HOSTS-1:0]                 i_host_read,
  input  logic [HOSTS-1:0]                 i_host_write,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0]   i_host_address,
  input  logic [HOSTS*BUS_WIDTH-1:0]       i_host_writedata,
  input  logic [HOSTS*(BUS_WIDTH/8)-1:0]   i_host_byteenable,
  output logic [HOSTS-1:0]                 o_host_waitrequest,
  output logic [1:0]                       o_host_response,
  output logic [BUS_WIDTH-1:0]             o_host_readdata,
  output logic                             o_agent_read,
  output logic                             o_agent_write,
  output logic [ADDRESS_WIDTH-1:0]         o_agent_address,
  output logic [BUS_WIDTH-1:0]             o_agent_writedata,
  output logic [BUS_WIDTH/8-1:0]           o_agent_byteenable,
  input  logic                             i_agent_waitrequest,
  input  logic [1:0]                       i_agent_response,
  input  logic [BUS_WIDTH-1:0]             i_agent_readdata,
  output logic [HOSTS-1:0]                 o_grant,
  output logic                             o_busy
);

  localparam int BE_WIDTH  = BUS_WIDTH / 8;
  localparam int PTR_WIDTH = (HOSTS > 1) ? $clog2(HOSTS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                 state_q;
  logic [HOSTS-1:0]       grant_q;
  logic [PTR_WIDTH-1:0]   ptr_q;

  logic [HOSTS-1:0]       req;
  logic [HOSTS-1:0]       select_d;
  logic [PTR_WIDTH-1:0]   ptr_d;
  logic [PTR_WIDTH-1:0]   grant_idx;
  logic [PTR_WIDTH:0]     scan_idx;
  logic                   found;
  logic                   busy;
  logic                   agent_read;
  logic                   agent_write;
  logic                   done;
  logic                   abort;

  assign req  = i_host_read | i_host_write;
  assign busy = (state_q == BUSY);

  // Pick the first requesting host, scanning upward from ptr and wrapping to 0.
  always_comb begin
    select_d = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < HOSTS; k++) begin
      scan_idx = {1'b0, ptr_q} + (PTR_WIDTH+1)'(k);
      if (scan_idx >= (PTR_WIDTH+1)'(HOSTS)) begin
        scan_idx = scan_idx - (PTR_WIDTH+1)'(HOSTS);
      end
      if (!found && req[scan_idx[PTR_WIDTH-1:0]]) begin
        select_d[scan_idx[PTR_WIDTH-1:0]] = 1'b1;
        found                             = 1'b1;
      end
    end
  end

  // Turn the one-hot grant into an index and work out the rotated pointer.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < HOSTS; i++) begin
      if (grant_q[i]) begin
        grant_idx = PTR_WIDTH'(i);
      end
    end
    if (grant_idx == PTR_WIDTH'(HOSTS - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = grant_idx + PTR_WIDTH'(1);
    end
  end

  // Route the granted host to the agent; idle data lines follow host 0.
  always_comb begin
    agent_read         = 1'b0;
    agent_write        = 1'b0;
    o_agent_address    = i_host_address[0 +: ADDRESS_WIDTH];
    o_agent_writedata  = i_host_writedata[0 +: BUS_WIDTH];
    o_agent_byteenable = i_host_byteenable[0 +: BE_WIDTH];
    o_host_waitrequest = '1;
    for (int i = 0; i < HOSTS; i++) begin
      if (busy && grant_q[i]) begin
        agent_read            = i_host_read[i];
        agent_write           = i_host_write[i];
        o_agent_address       = i_host_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        o_agent_writedata     = i_host_writedata[i*BUS_WIDTH +: BUS_WIDTH];
        o_agent_byteenable    = i_host_byteenable[i*BE_WIDTH +: BE_WIDTH];
        o_host_waitrequest[i] = i_agent_waitrequest;
      end
    end
  end

  assign done  = busy && (agent_read || agent_write) && !i_agent_waitrequest;
  assign abort = busy && !(agent_read || agent_write);

  // Arbitration FSM: latch a grant in IDLE, hold it until completion or abort.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= select_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= ptr_d;
          end else if (abort) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign o_agent_read    = agent_read;
  assign o_agent_write   = agent_write;
  assign o_host_response = i_agent_response;
  assign o_host_readdata = i_agent_readdata;
  assign o_grant         = grant_q;
  assign o_busy          = busy;

endmodule
